// File: rtl/plru_way_select_if.sv
// plru_way_select_if
//   Request/response bundle between the way encoder, the PLRU replacement
//   unit and the fill path.
//   flush               : synchronous clear of all PLRU state and counters
//   req_valid/set/hit/way : lookup result presented this cycle
//   resp_valid/set/way/hit: registered response (hit way echo or victim)
//   hit_cnt/miss_cnt    : saturating statistics counters
//   Modports: master drives requests, slave is the replacement unit.
interface plru_way_select_if #(
  parameter int SET_BITS = 4,
  parameter int CNT_W    = 16
);
  logic                flush;
  logic                req_valid;
  logic [SET_BITS-1:0] req_set;
  logic                req_hit;
  logic [2:0]          req_way;
  logic                resp_valid;
  logic [SET_BITS-1:0] resp_set;
  logic [2:0]          resp_way;
  logic                resp_hit;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W-1:0]    miss_cnt;

  modport master (
    output flush, req_valid, req_set, req_hit, req_way,
    input  resp_valid, resp_set, resp_way, resp_hit, hit_cnt, miss_cnt
  );

  modport slave (
    input  flush, req_valid, req_set, req_hit, req_way,
    output resp_valid, resp_set, resp_way, resp_hit, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/plru_way_select.sv
// plru_way_select
//   Per-set 8-way tree pseudo-LRU replacement unit. A hit marks the encoded
//   hit way most-recently-used; a miss picks a victim from the tree, marks it
//   most-recently-used and returns it. One response per accepted request,
//   registered one cycle later. Hit/miss counters saturate at all-ones.
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous active-high reset
//     bus  : plru_way_select_if slave modport (flush, req_*, resp_*, counters)
module plru_way_select #(
  parameter int SET_BITS = 4,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  plru_way_select_if.slave bus
);
  localparam int NUM_SETS = 2 ** SET_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Walk the tree from the root: b0 picks the half, b1/b2 the pair, b3..b6 the way.
  function automatic logic [2:0] plru_victim(input logic [6:0] t);
    logic       v2;
    logic       v1;
    logic [2:0] leaf;
    v2   = t[0];
    v1   = v2 ? t[2] : t[1];
    leaf = 3'd3 + {1'b0, v2, v1};
    return {v2, v1, t[leaf]};
  endfunction

  // Point every node on the path to way w away from w; other nodes keep their value.
  function automatic logic [6:0] plru_touch(input logic [6:0] t, input logic [2:0] w);
    logic [6:0] n;
    logic [2:0] leaf;
    n    = t;
    n[0] = ~w[2];
    if (w[2]) begin
      n[2] = ~w[1];
    end else begin
      n[1] = ~w[1];
    end
    leaf    = 3'd3 + {1'b0, w[2:1]};
    n[leaf] = ~w[0];
    return n;
  endfunction

  logic [6:0]          tree_q [NUM_SETS];
  logic                resp_valid_q, resp_valid_d;
  logic [SET_BITS-1:0] resp_set_q,   resp_set_d;
  logic [2:0]          resp_way_q,   resp_way_d;
  logic                resp_hit_q,   resp_hit_d;
  logic [CNT_W-1:0]    hit_cnt_q,    hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q,   miss_cnt_d;
  logic [6:0]          tree_d;
  logic [2:0]          access_way_s;
  logic                accept_s;

  // Next-state for the accessed set's tree, the response and the counters.
  always_comb begin
    accept_s     = bus.req_valid & ~bus.flush;
    access_way_s = bus.req_hit ? bus.req_way : plru_victim(tree_q[bus.req_set]);
    tree_d       = plru_touch(tree_q[bus.req_set], access_way_s);
    resp_valid_d = accept_s;
    resp_set_d   = resp_set_q;
    resp_way_d   = resp_way_q;
    resp_hit_d   = resp_hit_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (bus.flush) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (accept_s) begin
      resp_set_d = bus.req_set;
      resp_way_d = access_way_s;
      resp_hit_d = bus.req_hit;
      if (bus.req_hit) begin
        hit_cnt_d = (hit_cnt_q == CNT_MAX) ? hit_cnt_q : hit_cnt_q + CNT_ONE;
      end else begin
        miss_cnt_d = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + CNT_ONE;
      end
    end else begin
      resp_set_d = resp_set_q;
    end
  end

  // PLRU trees: cleared by reset or flush, one set updated per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        tree_q[s] <= 7'b0;
      end
    end else if (bus.flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        tree_q[s] <= 7'b0;
      end
    end else if (accept_s) begin
      tree_q[bus.req_set] <= tree_d;
    end
  end

  // Response and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_set_q   <= '0;
      resp_way_q   <= 3'd0;
      resp_hit_q   <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_set_q   <= resp_set_d;
      resp_way_q   <= resp_way_d;
      resp_hit_q   <= resp_hit_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_set   = resp_set_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.hit_cnt    = hit_cnt_q;
  assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_plru_way_select.sv
// tb_plru_way_select
//   Directed bench for plru_way_select. A reference model keeps each set's
//   tree as seven direction flags walked heap-style (node n -> children
//   2n+1 / 2n+2); a negedge process compares every DUT output with it each
//   cycle. Hand-computed literal expectations pin the model.
module tb_plru_way_select;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   chk_en;

  plru_way_select_if #(.SET_BITS(4), .CNT_W(16)) intf ();

  plru_way_select #(.SET_BITS(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] m_tree [16];
  logic       m_valid;
  logic [3:0] m_set;
  logic [2:0] m_way;
  logic       m_hit;
  int         m_hits;
  int         m_misses;

  function automatic logic [2:0] m_victim(input logic [6:0] t);
    int node = 0;
    int way  = 0;
    for (int lvl = 0; lvl < 3; lvl++) begin
      int dir = int'(t[node]);
      way  = way * 2 + dir;
      node = 2 * node + 1 + dir;
    end
    return 3'(way);
  endfunction

  function automatic logic [6:0] m_touch(input logic [6:0] t, input logic [2:0] w);
    int node = 0;
    logic [6:0] r = t;
    for (int lvl = 0; lvl < 3; lvl++) begin
      int dir = int'(w[2-lvl]);
      r[node] = (dir == 0) ? 1'b1 : 1'b0;
      node = 2 * node + 1 + dir;
    end
    return r;
  endfunction

  function automatic logic [2:0] m_pick(input logic h, input logic [2:0] w, input logic [6:0] t);
    return h ? w : m_victim(t);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 16; s++) m_tree[s] <= 7'd0;
      m_valid <= 1'b0; m_set <= 4'd0; m_way <= 3'd0; m_hit <= 1'b0;
      m_hits <= 0; m_misses <= 0;
    end else if (intf.flush) begin
      for (int s = 0; s < 16; s++) m_tree[s] <= 7'd0;
      m_valid <= 1'b0; m_hits <= 0; m_misses <= 0;
    end else begin
      m_valid <= intf.req_valid;
      if (intf.req_valid) begin
        m_set <= intf.req_set;
        m_hit <= intf.req_hit;
        m_way <= m_pick(intf.req_hit, intf.req_way, m_tree[intf.req_set]);
        m_tree[intf.req_set] <= m_touch(m_tree[intf.req_set],
                                        m_pick(intf.req_hit, intf.req_way, m_tree[intf.req_set]));
        if (intf.req_hit) m_hits <= (m_hits < 65535) ? m_hits + 1 : m_hits;
        else              m_misses <= (m_misses < 65535) ? m_misses + 1 : m_misses;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("resp_valid", {31'd0, intf.resp_valid}, {31'd0, m_valid});
      check("resp_set",   {28'd0, intf.resp_set},   {28'd0, m_set});
      check("resp_way",   {29'd0, intf.resp_way},   {29'd0, m_way});
      check("resp_hit",   {31'd0, intf.resp_hit},   {31'd0, m_hit});
      check("hit_cnt",    {16'd0, intf.hit_cnt},    32'(m_hits));
      check("miss_cnt",   {16'd0, intf.miss_cnt},   32'(m_misses));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] s, input logic h, input logic [2:0] w);
    @(negedge clk);
    intf.req_valid = 1'b1; intf.req_set = s; intf.req_hit = h; intf.req_way = w;
    intf.flush = 1'b0;
  endtask

  task automatic req_chk(input logic [3:0] s, input logic h, input logic [2:0] w,
                         input logic [2:0] exp_way, input string nm);
    drive(s, h, w);
    @(posedge clk); #1;
    check({nm, " valid"}, {31'd0, intf.resp_valid}, 32'd1);
    check({nm, " way"},   {29'd0, intf.resp_way},   {29'd0, exp_way});
  endtask

  task automatic idle();
    @(negedge clk);
    intf.req_valid = 1'b0; intf.flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    intf.req_valid = 1'b0; intf.flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [2:0] seq1 [8];

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b1;
    intf.flush = 1'b0; intf.req_valid = 1'b0; intf.req_set = 4'd0;
    intf.req_hit = 1'b0; intf.req_way = 3'd0;
    seq1[0] = 3'd0; seq1[1] = 3'd4; seq1[2] = 3'd2; seq1[3] = 3'd6;
    seq1[4] = 3'd1; seq1[5] = 3'd5; seq1[6] = 3'd3; seq1[7] = 3'd7;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset resp_valid", {31'd0, intf.resp_valid}, 32'd0);
    check("reset resp_way",   {29'd0, intf.resp_way},   32'd0);
    check("reset hit_cnt",    {16'd0, intf.hit_cnt},    32'd0);

    // 8 consecutive misses on set 0
    for (int i = 0; i < 8; i++) req_chk(4'd0, 1'b0, 3'd0, seq1[i], "miss seq");
    idle();
    @(posedge clk); #1;
    check("valid drops", {31'd0, intf.resp_valid}, 32'd0);
    check("way holds",   {29'd0, intf.resp_way},   32'd7);
    check("miss_cnt 8",  {16'd0, intf.miss_cnt},   32'd8);

    // set independence
    do_reset();
    req_chk(4'd3, 1'b1, 3'd0, 3'd0, "hit s3 w0");
    req_chk(4'd5, 1'b0, 3'd0, 3'd0, "miss s5");
    req_chk(4'd3, 1'b0, 3'd0, 3'd4, "miss s3");
    idle();
    @(posedge clk); #1;
    check("hit_cnt 1", {16'd0, intf.hit_cnt}, 32'd1);

    // alternating hits then misses on set 1
    do_reset();
    for (int i = 0; i < 4; i++) req_chk(4'd1, 1'b1, (i % 2 == 0) ? 3'd0 : 3'd4,
                                        (i % 2 == 0) ? 3'd0 : 3'd4, "alt hit");
    req_chk(4'd1, 1'b0, 3'd0, 3'd2, "alt miss1");
    req_chk(4'd1, 1'b1, 3'd2, 3'd2, "hit w2");
    req_chk(4'd1, 1'b0, 3'd0, 3'd6, "alt miss2");
    idle();

    // flush drops a same-cycle request
    req_chk(4'd2, 1'b0, 3'd0, 3'd0, "miss s2");
    @(negedge clk);
    intf.req_valid = 1'b1; intf.req_set = 4'd2; intf.req_hit = 1'b0; intf.flush = 1'b1;
    @(posedge clk); #1;
    check("flush valid", {31'd0, intf.resp_valid}, 32'd0);
    check("flush hits",  {16'd0, intf.hit_cnt},    32'd0);
    check("flush miss",  {16'd0, intf.miss_cnt},   32'd0);
    req_chk(4'd2, 1'b0, 3'd0, 3'd0, "post flush");
    idle();

    // hit counter saturation
    do_reset();
    for (int i = 0; i < 65534; i++) drive(4'(i % 16), 1'b1, 3'(i % 8));
    idle();
    @(posedge clk); #1;
    check("hit_cnt FFFE", {16'd0, intf.hit_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) drive(4'd7, 1'b1, 3'd1);
    idle();
    @(posedge clk); #1;
    check("hit_cnt sat", {16'd0, intf.hit_cnt}, 32'h0000FFFF);

    // asynchronous reset mid-stream
    do_reset();
    req_chk(4'd0, 1'b0, 3'd0, 3'd0, "pre rst a");
    req_chk(4'd0, 1'b0, 3'd0, 3'd4, "pre rst b");
    #2;
    rst = 1'b1;
    #1;
    check("async valid", {31'd0, intf.resp_valid}, 32'd0);
    check("async way",   {29'd0, intf.resp_way},   32'd0);
    check("async miss",  {16'd0, intf.miss_cnt},   32'd0);
    @(negedge clk);
    intf.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req_chk(4'd0, 1'b0, 3'd0, 3'd0, "post rst");
    idle();
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
